// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic array operand feeder.
package systolic_pkg;
  localparam int N_DEF     = 4;
  localparam int DW_DEF    = 8;
  localparam int K_MAX_DEF = 16;

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, STREAM, DONE} feeder_state_e;

  typedef logic signed [DW_DEF-1:0] operand_t;
endpackage

// File: rtl/skew_lane_sel.sv
// Picks the operand one edge lane presents at stream step t: column[t-lane]
// inside the valid window, zero padding outside it.
module skew_lane_sel #(
  parameter int K_MAX = 16,
  parameter int DW    = 8,
  parameter int TW    = 5,
  parameter int KW    = 5
) (
  input  logic [TW-1:0]             t,
  input  logic [TW-1:0]             lane,
  input  logic [KW-1:0]             k,
  input  logic [K_MAX-1:0][DW-1:0] col,
  output logic [DW-1:0]             val
);
  logic [TW-1:0] idx;

  // idx is only meaningful once t >= lane; the guard keeps the subtract from wrapping
  assign idx = t - lane;

  always_comb begin
    val = '0;
    if (t >= lane && idx < TW'(k))
      for (int m = 0; m < K_MAX; m++)
        if (idx == TW'(m)) val = col[m];
  end
endmodule

// File: rtl/systolic_skew_feeder.sv
// Buffers one K-beat operand tile, clears the array, then streams diagonally
// skewed A/B edges. FEEDER_TILE_CNT_EN adds a 16-bit completed-tile counter.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int K_MAX = K_MAX_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_a,
  input  logic [N*DW-1:0] in_b,
  input  logic            in_last,
  output logic            arr_clr,
  output logic [N*DW-1:0] arr_a,
  output logic [N*DW-1:0] arr_b,
  output logic            busy,
  output logic            done,
  output logic            ovf
`ifdef FEEDER_TILE_CNT_EN
  ,
  output logic [15:0]     tile_cnt
`endif
);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int TW = $clog2(K_MAX + 2*N);

  feeder_state_e state, state_n;
  logic [KW-1:0] kcnt, wr_idx;
  logic [TW-1:0] t, t_n, t_end;
  logic          xfer, at_cap;
  logic [N-1:0][K_MAX-1:0][DW-1:0] a_buf, b_buf;
  logic [N-1:0][DW-1:0] a_sel, b_sel, a_n, b_n;
  logic          clr_n, done_n;

  assign in_ready = (state == IDLE) || (state == LOAD);
  assign xfer     = in_valid && in_ready;
  assign wr_idx   = (state == IDLE) ? '0 : kcnt;
  assign at_cap   = (wr_idx + KW'(1)) == KW'(K_MAX);
  assign ovf      = xfer && at_cap && !in_last;
  // kcnt stays put from CLEAR until the next tile's first beat, so it doubles as K
  assign t_end    = TW'(kcnt) + TW'(2*N - 3);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      kcnt  <= '0;
      t     <= '0;
    end else begin
      state <= state_n;
      t     <= t_n;
      if (xfer) kcnt <= wr_idx + KW'(1);
    end

  always_comb begin
    state_n = state;
    t_n     = t;
    case (state)
      IDLE, LOAD: if (xfer) state_n = (in_last || at_cap) ? CLEAR : LOAD;
      CLEAR: begin
        state_n = STREAM;
        t_n     = '0;
      end
      STREAM: if (t == t_end) state_n = DONE; else t_n = t + TW'(1);
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (xfer)
      for (int m = 0; m < K_MAX; m++)
        if (wr_idx == KW'(m))
          for (int i = 0; i < N; i++) begin
            a_buf[i][m] <= in_a[i*DW +: DW];
            b_buf[i][m] <= in_b[i*DW +: DW];
          end

  // Lanes look at next-cycle t so the registered edges line up with the state
  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_lane_sel #(.K_MAX(K_MAX), .DW(DW), .TW(TW), .KW(KW)) u_a (
      .t(t_n), .lane(TW'(g)), .k(kcnt), .col(a_buf[g]), .val(a_sel[g]));
    skew_lane_sel #(.K_MAX(K_MAX), .DW(DW), .TW(TW), .KW(KW)) u_b (
      .t(t_n), .lane(TW'(g)), .k(kcnt), .col(b_buf[g]), .val(b_sel[g]));
  end

  always_comb begin
    clr_n  = (state_n == CLEAR);
    done_n = (state_n == DONE);
    a_n    = '0;
    b_n    = '0;
    if (state_n == STREAM) begin
      a_n = a_sel;
      b_n = b_sel;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      arr_clr  <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      arr_a    <= '0;
      arr_b    <= '0;
`ifdef FEEDER_TILE_CNT_EN
      tile_cnt <= '0;
`endif
    end else begin
      arr_clr  <= clr_n;
      done     <= done_n;
      busy     <= (state_n != IDLE);
      arr_a    <= a_n;
      arr_b    <= b_n;
`ifdef FEEDER_TILE_CNT_EN
      if (done_n) tile_cnt <= tile_cnt + 16'd1;
`endif
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed/random bench: edge values against the skew rule, and an attached
// output-stationary array model whose results must equal A*B at done.
module tb_systolic_skew_feeder;
  import systolic_pkg::*;
  localparam int N = 4, DW = 8, K_MAX = 16;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0;
  logic [N*DW-1:0] in_a = '0, in_b = '0;
  logic in_ready, arr_clr, busy, done, ovf;
  logic [N*DW-1:0] arr_a, arr_b;
`ifdef FEEDER_TILE_CNT_EN
  logic [15:0] tile_cnt;
`endif

  int pass_cnt = 0, chk_cnt = 0, done_seen = 0;
  operand_t ma [0:31][0:N-1];  // ma[k][i] = A[i][k]
  operand_t mb [0:31][0:N-1];  // mb[k][j] = B[k][j]
  int acc [N][N], pa [N][N], pb [N][N], ain [N][N], bin [N][N];

  systolic_skew_feeder #(.N(N), .K_MAX(K_MAX), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .arr_clr(arr_clr),
    .arr_a(arr_a), .arr_b(arr_b), .busy(busy), .done(done), .ovf(ovf)
`ifdef FEEDER_TILE_CNT_EN
    , .tile_cnt(tile_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Output-stationary array: A moves east, B moves south, one hop per cycle
  always_comb begin
    ain = '{default: 0};
    bin = '{default: 0};
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (j == 0) ain[i][j] = $signed(arr_a[i*DW +: DW]);
        else        ain[i][j] = pa[i][j-1];
        if (i == 0) bin[i][j] = $signed(arr_b[j*DW +: DW]);
        else        bin[i][j] = pb[i-1][j];
      end
  end

  always @(posedge clk)
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (arr_clr) begin
          acc[i][j] <= 0;
          pa[i][j]  <= 0;
          pb[i][j]  <= 0;
        end else begin
          acc[i][j] <= acc[i][j] + ain[i][j] * bin[i][j];
          pa[i][j]  <= ain[i][j];
          pb[i][j]  <= bin[i][j];
        end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
  endtask

  task automatic fill(input int n);
    for (int b = 0; b < n; b++)
      for (int i = 0; i < N; i++) begin
        ma[b][i] = operand_t'($urandom);
        mb[b][i] = operand_t'($urandom);
      end
  endtask

  task automatic drive_beat(input int b, input bit last);
    in_valid = 1'b1;
    in_last  = last;
    for (int i = 0; i < N; i++) begin
      in_a[i*DW +: DW] = ma[b][i];
      in_b[i*DW +: DW] = mb[b][i];
    end
  endtask

  // Presents beats off..off+K-1; hold_next leaves beat off+K on the bus afterwards
  task automatic send(input int off, input int K, input bit use_last, input bit gaps, input bit hold_next);
    for (int k = 0; k < K; k++) begin
      @(negedge clk);
      drive_beat(off + k, use_last && k == K-1);
      #1;
      chk("in_ready", in_ready, 1);
      chk("ovf", ovf, (k == K_MAX-1) && !(use_last && k == K-1));
      if (k == 0) chk("busy_idle", busy, 0);
      @(posedge clk);
      if (gaps && k < K-1) begin
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("gap_clr_rdy_busy", {arr_clr, in_ready, busy}, 3'b011);
        @(posedge clk);
      end
    end
    #1;
    if (hold_next) drive_beat(off + K, 1'b0);
    else begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  // Cycle c=1 is CLEAR, c=2.. is STREAM step t=c-2, c=K+2N is DONE
  task automatic watch(input int off, input int K, input int stop_c);
    int cexp [N][N];
    logic [N*DW-1:0] ea, eb;
    cexp = '{default: 0};
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < K; k++)
          cexp[i][j] += ma[off+k][i] * mb[off+k][j];
    for (int c = 1; c <= stop_c; c++) begin
      int t;
      @(negedge clk);
      t  = c - 2;
      ea = '0;
      eb = '0;
      for (int i = 0; i < N; i++)
        if (t >= i && t - i < K && t <= K + 2*N - 3) begin
          ea[i*DW +: DW] = ma[off + t - i][i];
          eb[i*DW +: DW] = mb[off + t - i][i];
        end
      chk("arr_clr", arr_clr, c == 1);
      chk("done", done, c == K + 2*N);
      chk("ready_busy_ovf", {in_ready, busy, ovf}, 3'b010);
      chk("arr_a", arr_a, ea);
      chk("arr_b", arr_b, eb);
      if (done) done_seen++;
      if (c == K + 2*N)
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            chk("pe_result", acc[i][j], cexp[i][j]);
    end
  endtask

  initial begin
    int dcount;
    repeat (2) @(negedge clk);
    chk("rst_edges", {arr_a, arr_b}, '0);
    chk("rst_ctl", {arr_clr, done, busy, ovf, in_ready}, 5'b00001);
    rst = 1'b0;

    // single beat, lane i = i+1 on A and i+5 on B
    for (int i = 0; i < N; i++) begin
      ma[0][i] = operand_t'(i + 1);
      mb[0][i] = operand_t'(i + 5);
    end
    send(0, 1, 1, 0, 0);
    watch(0, 1, 1 + 2*N);

    // identity A against row-index B: results must equal B
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < N; i++) begin
        ma[k][i] = operand_t'(i == k);
        mb[k][i] = operand_t'(k);
      end
    send(0, 4, 1, 0, 0);
    watch(0, 4, 4 + 2*N);

    // valid toggling over a 3-beat tile
    fill(3);
    send(0, 3, 1, 1, 0);
    watch(0, 3, 3 + 2*N);

    // 20 beats without last: truncated at 16, the rest form the next tile
    fill(20);
    send(0, 16, 0, 0, 1);
    watch(0, 16, 16 + 2*N);
    send(16, 4, 1, 0, 0);
    watch(16, 4, 4 + 2*N);

    for (int r = 0; r < 4; r++) begin
      int K;
      K = $urandom_range(1, K_MAX);
      fill(K);
      send(0, K, 1, $urandom_range(0, 1), 0);
      watch(0, K, K + 2*N);
    end

    // reset in the middle of STREAM (t=2)
    fill(4);
    send(0, 4, 1, 0, 0);
    watch(0, 4, 4);
    rst = 1'b1;
    #1;
    chk("midrst_edges", {arr_a, arr_b}, '0);
    chk("midrst_ctl", {arr_clr, done, busy, ovf, in_ready}, 5'b00001);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("no_done_after_rst", dcount, 0);

    for (int r = 0; r < 3; r++) begin
      int K;
      K = $urandom_range(1, 6);
      fill(K);
      send(0, K, 1, 0, 0);
      watch(0, K, K + 2*N);
    end
`ifdef FEEDER_TILE_CNT_EN
    chk("tile_cnt", tile_cnt, 3);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
